pipe_spawn_sched: RTL and testbench

Schedules pipe spawns for the game loop. Counts frames and draws a gap height from the free-running 7-bit LFSR value. Rejection-samples that value into a legal gap window, limits the jump from the previous gap, then assigns the pipe to a free column slot (round-robin) through a valid/ready handshake. It sits between random_gen and the pipe movers/renderer.

---
 rtl/pipe_spawn_sched_pkg.sv | 39 +++
 rtl/pipe_spawn_sched_rr_slot_pick.sv | 48 ++++
 rtl/pipe_spawn_sched.sv | 212 +++++++++++++++++++++
 tb/tb_pipe_spawn_sched.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_spawn_sched_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pipe_spawn_sched_pkg                                            |
// | Purpose  : Shared types and constants for the pipe spawn scheduler and    |
// |            its slot picker: FSM state encoding, random/gap/slot widths,   |
// |            the pipe spawn record and a saturating counter helper.         |
// | Ports    : none (package)                                                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package pipe_spawn_sched_pkg;

  // Width of the random_gen output consumed by the draw stage.
  localparam int RAND_W = 7;
  // Gap y coordinate width (screen rows 0..127).
  localparam int GAP_W  = 7;
  // Slot index width; covers up to four pipe columns.
  localparam int SLOT_W = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_COUNT  = 3'd1,
    ST_DRAW   = 3'd2,
    ST_SELECT = 3'd3,
    ST_ISSUE  = 3'd4
  } state_t;

  // One pipe spawn as offered to the movers/renderer.
  typedef struct packed {
    logic [GAP_W-1:0]  gap_y;
    logic [SLOT_W-1:0] slot;
  } spawn_rec_t;

  // 8-bit increment that sticks at 255.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_spawn_sched_rr_slot_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rr_slot_pick                                                    |
// | Purpose  : Combinational round-robin first-free search. Starting just     |
// |            after i_last_slot and wrapping modulo NUM_SLOTS, returns the   |
// |            first slot whose i_slot_free bit is set.                       |
// | Ports    : i_slot_free [NUM_SLOTS] - bit i set = slot i available         |
// |            i_last_slot [SLOT_W]    - most recently granted slot           |
// |            o_found                 - at least one slot is free            |
// |            o_idx       [SLOT_W]    - chosen slot (0 when none found)      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module rr_slot_pick
  import pipe_spawn_sched_pkg::*;
#(
  parameter int NUM_SLOTS = 3
) (
  input  logic [NUM_SLOTS-1:0] i_slot_free,
  input  logic [SLOT_W-1:0]    i_last_slot,
  output logic                 o_found,
  output logic [SLOT_W-1:0]    o_idx
);

  localparam int c_W = SLOT_W + 1;

  logic [c_W-1:0] w_cand;

  // Walk from the farthest offset down to the nearest so the nearest free
  // slot is the last one written and therefore wins. last_slot + k never
  // exceeds 2*NUM_SLOTS-1, so a single conditional subtract is the modulo.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    w_cand  = '0;
    for (int k = NUM_SLOTS; k >= 1; k--) begin
      w_cand = {1'b0, i_last_slot} + c_W'(k);
      if (w_cand >= c_W'(NUM_SLOTS)) begin
        w_cand = w_cand - c_W'(NUM_SLOTS);
      end
      if (i_slot_free[w_cand[SLOT_W-1:0]]) begin
        o_found = 1'b1;
        o_idx   = w_cand[SLOT_W-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pipe_spawn_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pipe_spawn_sched                                                |
// | Purpose  : Pipe spawn scheduler for the game loop. Counts frames, draws a |
// |            gap height from the LFSR by rejection sampling, limits the    |
// |            step from the previous gap, picks a free column slot          |
// |            round-robin and offers the spawn over valid/ready.            |
// | Ports    : clk            - system clock, rising edge                     |
// |            resetn         - asynchronous active-low reset                 |
// |            enable         - game running; 0 aborts and idles              |
// |            frame_tick     - one-cycle pulse per frame                     |
// |            rand_in   [7]  - current random_gen value                      |
// |            slot_free [N]  - bit i set = slot i available                  |
// |            spawn_ready    - pipe logic accepts the spawn                  |
// |            spawn_valid    - spawn offer pending                           |
// |            spawn_gap_y [7]- gap y of the offered pipe                     |
// |            spawn_slot  [2]- slot index of the offered pipe                |
// |            missed_spawns[8]- spawns dropped for lack of a slot (sat.)     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module pipe_spawn_sched
  import pipe_spawn_sched_pkg::*;
#(
  parameter int SPAWN_PERIOD = 90,
  parameter int GAP_MIN      = 20,
  parameter int GAP_MAX      = 90,
  parameter int MAX_STEP     = 24,
  parameter int MAX_TRIES    = 4,
  parameter int NUM_SLOTS    = 3
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 enable,
  input  logic                 frame_tick,
  input  logic [RAND_W-1:0]    rand_in,
  input  logic [NUM_SLOTS-1:0] slot_free,
  input  logic                 spawn_ready,
  output logic                 spawn_valid,
  output logic [GAP_W-1:0]     spawn_gap_y,
  output logic [SLOT_W-1:0]    spawn_slot,
  output logic [7:0]           missed_spawns
);

  localparam int c_CNT_W = (SPAWN_PERIOD > 2) ? $clog2(SPAWN_PERIOD) : 1;
  localparam int c_TRY_W = $clog2(MAX_TRIES + 1);

  localparam logic [c_CNT_W-1:0] c_RELOAD    = c_CNT_W'(SPAWN_PERIOD - 1);
  localparam logic [c_TRY_W-1:0] c_LAST_TRY  = c_TRY_W'(MAX_TRIES - 1);
  localparam logic [7:0]         c_RANGE     = 8'(GAP_MAX - GAP_MIN + 1);
  localparam logic [7:0]         c_GAP_MIN8  = 8'(GAP_MIN);
  localparam logic [GAP_W-1:0]   c_GAP_MID   = GAP_W'((GAP_MIN + GAP_MAX) / 2);
  localparam logic [SLOT_W-1:0]  c_SLOT_LAST = SLOT_W'(NUM_SLOTS - 1);

  // Signed 9-bit limits: prev_gap + MAX_STEP can exceed 127, so one bit
  // beyond an 8-bit signed value keeps both window edges exact.
  localparam logic signed [8:0] c_STEP_S = 9'(MAX_STEP);
  localparam logic signed [8:0] c_MIN_S  = 9'(GAP_MIN);
  localparam logic signed [8:0] c_MAX_S  = 9'(GAP_MAX);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [c_CNT_W-1:0]  r_counter;
  logic [c_TRY_W-1:0]  r_tries;
  logic [GAP_W-1:0]    r_cand;
  logic [GAP_W-1:0]    r_prev_gap;
  logic [SLOT_W-1:0]   r_last_slot;
  spawn_rec_t          r_rec;
  logic [7:0]          r_missed;

  logic                w_draw_ok;
  logic [GAP_W-1:0]    w_draw_gap;
  logic                w_last_draw;
  logic                w_expire;
  logic                w_handshake;
  logic                w_slot_found;
  logic [SLOT_W-1:0]   w_slot_idx;
  logic signed [8:0]   w_prev_s;
  logic signed [8:0]   w_cand_s;
  logic signed [8:0]   w_lo;
  logic signed [8:0]   w_hi;
  logic signed [8:0]   w_step_c;
  logic signed [8:0]   w_gap_c;
  logic [GAP_W-1:0]    w_gap_sel;

  // Rejection sampling: only values below RANGE map onto the gap window,
  // which keeps the distribution uniform without a divider.
  assign w_draw_ok   = ({1'b0, rand_in} < c_RANGE);
  assign w_draw_gap  = GAP_W'(c_GAP_MIN8 + {1'b0, rand_in});
  assign w_last_draw = (r_tries == c_LAST_TRY);
  assign w_expire    = frame_tick && (r_counter == '0);
  assign w_handshake = (r_state == ST_ISSUE) && spawn_ready;

  // Step limit around the previous gap, then the absolute gap window.
  always_comb begin
    w_prev_s = $signed({2'b00, r_prev_gap});
    w_cand_s = $signed({2'b00, r_cand});
    w_lo     = w_prev_s - c_STEP_S;
    w_hi     = w_prev_s + c_STEP_S;
    w_step_c = (w_cand_s < w_lo) ? w_lo : ((w_cand_s > w_hi) ? w_hi : w_cand_s);
    w_gap_c  = (w_step_c < c_MIN_S) ? c_MIN_S :
               ((w_step_c > c_MAX_S) ? c_MAX_S : w_step_c);
  end

  assign w_gap_sel = GAP_W'(w_gap_c);

  rr_slot_pick #(
    .NUM_SLOTS (NUM_SLOTS)
  ) u_slot_pick (
    .i_slot_free (slot_free),
    .i_last_slot (r_last_slot),
    .o_found     (w_slot_found),
    .o_idx       (w_slot_idx)
  );

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; dropping enable wins from every state.
  always_comb begin
    w_state_nxt = r_state;
    if (!enable) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:   w_state_nxt = ST_COUNT;
        ST_COUNT:  if (w_expire) w_state_nxt = ST_DRAW;
        ST_DRAW:   if (w_draw_ok || w_last_draw) w_state_nxt = ST_SELECT;
        ST_SELECT: w_state_nxt = w_slot_found ? ST_ISSUE : ST_COUNT;
        ST_ISSUE:  if (spawn_ready) w_state_nxt = ST_COUNT;
        default:   w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Outputs: valid is decoded from state, payload comes straight from the
  // registered spawn record so it is stable for the whole offer.
  always_comb begin
    spawn_valid   = (r_state == ST_ISSUE);
    spawn_gap_y   = r_rec.gap_y;
    spawn_slot    = r_rec.slot;
    missed_spawns = r_missed;
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_counter   <= c_RELOAD;
      r_tries     <= '0;
      r_cand      <= '0;
      r_prev_gap  <= c_GAP_MID;
      r_last_slot <= c_SLOT_LAST;
      r_rec       <= '0;
      r_missed    <= '0;
    end else begin
      // A completed handshake is history for the next gap/slot choice even
      // if enable falls in the same cycle: the receiver has taken the pipe.
      if (w_handshake) begin
        r_prev_gap  <= r_rec.gap_y;
        r_last_slot <= r_rec.slot;
      end
      if (!enable) begin
        r_counter <= c_RELOAD;
        r_tries   <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_counter <= c_RELOAD;
          end
          ST_COUNT: begin
            r_tries <= '0;
            if (frame_tick && (r_counter != '0)) begin
              r_counter <= r_counter - c_CNT_W'(1);
            end
          end
          ST_DRAW: begin
            if (w_draw_ok) begin
              r_cand <= w_draw_gap;
            end else begin
              r_tries <= r_tries + c_TRY_W'(1);
              if (w_last_draw) begin
                r_cand <= r_prev_gap;
              end
            end
          end
          ST_SELECT: begin
            if (w_slot_found) begin
              r_rec.gap_y <= w_gap_sel;
              r_rec.slot  <= w_slot_idx;
            end else begin
              r_missed  <= sat_inc8(r_missed);
              r_counter <= c_RELOAD;
            end
          end
          ST_ISSUE: begin
            if (spawn_ready) begin
              r_counter <= c_RELOAD;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_spawn_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_pipe_spawn_sched                                             |
// | Purpose  : Self-checking bench for pipe_spawn_sched. A driver issues      |
// |            frame ticks, draw values, slot masks and ready patterns and   |
// |            pushes the expected spawn (gap, slot, cycle of offer) into a  |
// |            queue; a monitor pops and compares whenever an offer appears. |
// | Ports    : none                                                            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_pipe_spawn_sched;

  localparam int SP    = 4;
  localparam int GMIN  = 20;
  localparam int GMAX  = 90;
  localparam int STEP  = 24;
  localparam int TRIES = 4;
  localparam int NS    = 3;
  localparam int RANGE = GMAX - GMIN + 1;

  logic       clk = 1'b0;
  logic       resetn;
  logic       enable;
  logic       frame_tick;
  logic [6:0] rand_in;
  logic [2:0] slot_free;
  logic       spawn_ready;
  logic       spawn_valid;
  logic [6:0] spawn_gap_y;
  logic [1:0] spawn_slot;
  logic [7:0] missed_spawns;

  pipe_spawn_sched #(
    .SPAWN_PERIOD (SP),
    .GAP_MIN      (GMIN),
    .GAP_MAX      (GMAX),
    .MAX_STEP     (STEP),
    .MAX_TRIES    (TRIES),
    .NUM_SLOTS    (NS)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .enable        (enable),
    .frame_tick    (frame_tick),
    .rand_in       (rand_in),
    .slot_free     (slot_free),
    .spawn_ready   (spawn_ready),
    .spawn_valid   (spawn_valid),
    .spawn_gap_y   (spawn_gap_y),
    .spawn_slot    (spawn_slot),
    .missed_spawns (missed_spawns)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int gap;
    int slot;
    int cyc;
  } exp_t;
  exp_t exp_q[$];

  // Reference state at spawn granularity.
  int m_prev   = (GMIN + GMAX) / 2;
  int m_last   = NS - 1;
  int m_missed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, want, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_gap(input int cand, input int prev);
    int g;
    g = cand;
    if (g < prev - STEP) g = prev - STEP;
    if (g > prev + STEP) g = prev + STEP;
    if (g < GMIN) g = GMIN;
    if (g > GMAX) g = GMAX;
    return g;
  endfunction

  function automatic int model_slot(input logic [2:0] sf, input int last);
    for (int k = 1; k <= NS; k++) begin
      if (sf[(last + k) % NS]) return (last + k) % NS;
    end
    return -1;
  endfunction

  // One spawn period starting with the DUT counting from a full reload.
  task automatic epoch(input int nrej, input bit fallback, input int acc,
                       input logic [2:0] sfree, input int bp, input bit noise,
                       input bit abort);
    int   draws[$];
    int   tick_cyc;
    int   g;
    int   s;
    exp_t e;
    slot_free = sfree;
    for (int i = 0; i < nrej; i++) begin
      draws.push_back((i == 0) ? RANGE : int'($urandom_range(RANGE, 127)));
    end
    if (!fallback) draws.push_back(acc);
    for (int t = 0; t < SP; t++) begin
      repeat ($urandom_range(0, 2)) begin
        frame_tick = 1'b0;
        rand_in    = 7'($urandom);
        step();
      end
      frame_tick = 1'b1;
      step();
    end
    tick_cyc = cyc;
    foreach (draws[i]) begin
      frame_tick = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      rand_in    = 7'(draws[i]);
      step();
    end
    g = model_gap(fallback ? m_prev : GMIN + acc, m_prev);
    s = model_slot(sfree, m_last);
    if (s >= 0) begin
      e.gap  = g;
      e.slot = s;
      e.cyc  = tick_cyc + draws.size() + 1;
      exp_q.push_back(e);
    end
    frame_tick = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    rand_in    = 7'($urandom);
    step();
    if (s < 0) begin
      m_missed = (m_missed < 255) ? m_missed + 1 : 255;
      chk("missed_count", missed_spawns, m_missed);
      chk("miss_no_valid", spawn_valid, 0);
      frame_tick = 1'b0;
      return;
    end
    for (int b = 0; b < bp; b++) begin
      frame_tick = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      slot_free  = 3'($urandom);
      step();
    end
    if (abort) begin
      enable     = 1'b0;
      frame_tick = 1'b0;
      step();
      chk("abort_valid_drop", spawn_valid, 0);
      enable = 1'b1;
      step();
      return;
    end
    chk("valid_before_hs", spawn_valid, 1);
    spawn_ready = 1'b1;
    step();
    spawn_ready = 1'b0;
    frame_tick  = 1'b0;
    m_prev = g;
    m_last = s;
    chk("valid_after_hs", spawn_valid, 0);
  endtask

  // Monitor: compares every new offer with the head of the expectation queue
  // and checks the payload stays put while the offer is pending.
  logic       mon_prev_valid = 1'b0;
  logic [6:0] mon_gap;
  logic [1:0] mon_slot;
  always @(negedge clk) begin
    exp_t e;
    if (!resetn) begin
      mon_prev_valid = 1'b0;
    end else begin
      if (spawn_valid && !mon_prev_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got offer gap %0d slot %0d, none expected",
                   spawn_gap_y, spawn_slot);
        end else begin
          e = exp_q.pop_front();
          chk("spawn_gap", spawn_gap_y, e.gap);
          chk("spawn_slot", spawn_slot, e.slot);
          chk("spawn_cycle", cyc, e.cyc);
        end
        mon_gap  = spawn_gap_y;
        mon_slot = spawn_slot;
      end else if (spawn_valid && mon_prev_valid) begin
        chk("gap_stable", spawn_gap_y, mon_gap);
        chk("slot_stable", spawn_slot, mon_slot);
      end
      mon_prev_valid = spawn_valid;
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int  nrej;
    resetn      = 1'b0;
    enable      = 1'b0;
    frame_tick  = 1'b0;
    rand_in     = '0;
    slot_free   = '0;
    spawn_ready = 1'b0;
    step();
    step();
    chk("reset_valid", spawn_valid, 0);
    chk("reset_gap", spawn_gap_y, 0);
    chk("reset_slot", spawn_slot, 0);
    chk("reset_missed", missed_spawns, 0);
    resetn = 1'b1;
    step();
    enable = 1'b1;
    step();

    // Directed: basic spawn, rejections, fallback, miss, slot wrap, backpressure.
    epoch(0, 1'b0, 10, 3'b111, 0, 1'b0, 1'b0);
    epoch(3, 1'b0, 40, 3'b111, 0, 1'b0, 1'b0);
    epoch(TRIES, 1'b1, 0, 3'b111, 0, 1'b0, 1'b0);
    epoch(0, 1'b0, 5, 3'b000, 0, 1'b0, 1'b0);
    epoch(0, 1'b0, RANGE - 1, 3'b111, 0, 1'b0, 1'b0);
    epoch(1, 1'b0, 0, 3'b101, 0, 1'b0, 1'b0);
    epoch(0, 1'b0, 35, 3'b111, 10, 1'b1, 1'b0);
    epoch(1, 1'b0, 60, 3'b111, 2, 1'b1, 1'b1);
    epoch(0, 1'b0, 30, 3'b011, 1, 1'b1, 1'b0);

    // Randomised spawn periods.
    for (int n = 0; n < 40; n++) begin
      nrej = $urandom_range(0, TRIES);
      epoch(nrej, nrej == TRIES, $urandom_range(0, RANGE - 1), 3'($urandom),
            $urandom_range(0, 3), 1'b1, $urandom_range(0, 9) == 0);
    end

    // Saturation of the missed counter.
    for (int n = 0; n < 260; n++) begin
      epoch(0, 1'b0, $urandom_range(0, RANGE - 1), 3'b000, 0, 1'b0, 1'b0);
    end

    // Asynchronous reset in the middle of a draw.
    slot_free = 3'b111;
    for (int t = 0; t < SP; t++) begin
      frame_tick = 1'b1;
      step();
    end
    frame_tick = 1'b0;
    rand_in    = 7'd127;
    #3;
    resetn = 1'b0;
    #1;
    chk("async_reset_valid", spawn_valid, 0);
    chk("async_reset_gap", spawn_gap_y, 0);
    chk("async_reset_slot", spawn_slot, 0);
    chk("async_reset_missed", missed_spawns, 0);
    exp_q.delete();
    m_prev   = (GMIN + GMAX) / 2;
    m_last   = NS - 1;
    m_missed = 0;
    step();
    resetn = 1'b1;
    step();
    epoch(0, 1'b0, 70, 3'b111, 0, 1'b0, 1'b0);
    epoch(TRIES, 1'b1, 0, 3'b110, 1, 1'b1, 1'b0);

    step();
    step();
    chk("pending_expected", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
